// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Memory-port control encodings and arbiter state type.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] c_WC_NONE = 2'b00;
    localparam logic [1:0] c_WC_HALF = 2'b01;
    localparam logic [1:0] c_WC_BYTE = 2'b10;
    localparam logic [1:0] c_WC_WORD = 2'b11;

    localparam logic [2:0] c_RC_NONE = 3'b000;
    localparam logic [2:0] c_RC_LW   = 3'b001;
    localparam logic [2:0] c_RC_LHU  = 3'b010;
    localparam logic [2:0] c_RC_LH   = 3'b011;
    localparam logic [2:0] c_RC_LBU  = 3'b100;
    localparam logic [2:0] c_RC_LB   = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    function automatic logic is_load(input logic [2:0] rc);
        return (rc >= c_RC_LW) && (rc <= c_RC_LB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin arbiter; bit 0 = I-port, bit 1 = D-port.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 #(
    parameter int RESET_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_prio;   // 0 favours the I-port on a tie, 1 favours the D-port

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= (RESET_PRIO != 0);
        end else if (i_advance && (o_grant != 2'b00)) begin
            r_prio <= o_grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one RAM port between instruction fetch and data access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_write_ctrl,
    input  logic [2:0]  d_read_ctrl,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_write_ctrl,
    output logic [2:0]  mem_read_ctrl,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic [1:0]  w_grant;
    logic        w_take;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_wctrl;
    logic [2:0]  r_rctrl;
    logic        r_win_d;

    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_wctrl;
    logic [2:0]  w_rctrl;

    assign w_take = (r_state == IDLE) && (i_req || d_req);

    rr_arbiter2 #(
        .RESET_PRIO (RESET_PRIO)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({d_req, i_req}),
        .i_advance (w_take),
        .o_grant   (w_grant)
    );

    // Request decode: a D-port no-op latches all-zero fields so the RAM bus stays idle.
    always_comb begin
        w_addr  = 32'd0;
        w_wdata = 32'd0;
        w_wctrl = c_WC_NONE;
        w_rctrl = c_RC_NONE;
        if (w_grant[0]) begin
            w_addr  = i_addr;
            w_rctrl = c_RC_LW;
        end else if (d_write_ctrl != c_WC_NONE) begin
            w_addr  = d_addr;
            w_wdata = d_wdata;
            w_wctrl = d_write_ctrl;
        end else if (is_load(d_read_ctrl)) begin
            w_addr  = d_addr;
            w_rctrl = d_read_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wctrl <= c_WC_NONE;
            r_rctrl <= c_RC_NONE;
            r_win_d <= 1'b0;
        end else if (w_take) begin
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wctrl <= w_wctrl;
            r_rctrl <= w_rctrl;
            r_win_d <= w_grant[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_take ? ACCESS : IDLE;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus is driven purely from state, so an async reset idles it at once.
    always_comb begin
        mem_addr       = 32'd0;
        mem_wdata      = 32'd0;
        mem_write_ctrl = c_WC_NONE;
        mem_read_ctrl  = c_RC_NONE;
        i_ack          = 1'b0;
        d_ack          = 1'b0;
        case (r_state)
            ACCESS: begin
                mem_addr       = r_addr;
                mem_wdata      = r_wdata;
                mem_write_ctrl = r_wctrl;
                mem_read_ctrl  = r_rctrl;
            end
            RESP: begin
                i_ack = ~r_win_d;
                d_ack = r_win_d;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else if (r_state == ACCESS) begin
            if (r_win_d) begin
                d_rdata <= (r_rctrl != c_RC_NONE) ? mem_rdata : 32'd0;
            end else begin
                i_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [1:0]  d_write_ctrl = 2'b00;
    logic [2:0]  d_read_ctrl = 3'b000;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_write_ctrl;
    logic [2:0]  mem_read_ctrl;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .RESET_PRIO (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ack          (i_ack),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_write_ctrl   (d_write_ctrl),
        .d_read_ctrl    (d_read_ctrl),
        .d_ack          (d_ack),
        .d_rdata        (d_rdata),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_write_ctrl (mem_write_ctrl),
        .mem_read_ctrl  (mem_read_ctrl),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    // Little-endian byte RAM; reads are combinational and size/sign-aware.
    logic [7:0]  ram [0:511];
    logic        pl_we = 1'b0;
    logic [8:0]  pl_addr = 9'd0;
    logic [31:0] pl_word = 32'd0;
    logic [8:0]  ra;
    logic [7:0]  rb0, rb1, rb2, rb3;

    assign ra  = mem_addr[8:0];
    assign rb0 = ram[ra];
    assign rb1 = ram[ra + 9'd1];
    assign rb2 = ram[ra + 9'd2];
    assign rb3 = ram[ra + 9'd3];

    always_comb begin
        case (mem_read_ctrl)
            3'b001:  mem_rdata = {rb3, rb2, rb1, rb0};
            3'b010:  mem_rdata = {16'h0000, rb1, rb0};
            3'b011:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
            3'b100:  mem_rdata = {24'h000000, rb0};
            3'b101:  mem_rdata = {{24{rb0[7]}}, rb0};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_addr]        <= pl_word[7:0];
            ram[pl_addr + 9'd1] <= pl_word[15:8];
            ram[pl_addr + 9'd2] <= pl_word[23:16];
            ram[pl_addr + 9'd3] <= pl_word[31:24];
        end else begin
            case (mem_write_ctrl)
                2'b11: begin
                    ram[ra]        <= mem_wdata[7:0];
                    ram[ra + 9'd1] <= mem_wdata[15:8];
                    ram[ra + 9'd2] <= mem_wdata[23:16];
                    ram[ra + 9'd3] <= mem_wdata[31:24];
                end
                2'b01: begin
                    ram[ra]        <= mem_wdata[7:0];
                    ram[ra + 9'd1] <= mem_wdata[15:8];
                end
                2'b10: ram[ra] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] ram_word(input logic [8:0] a);
        return {ram[a + 9'd3], ram[a + 9'd2], ram[a + 9'd1], ram[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] w);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_word = w;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    // Issues one D-port request from an IDLE negedge; samples the bus in ACCESS.
    task automatic d_access(input logic [1:0] wc, input logic [2:0] rc,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat,
                            output logic [31:0] acc_ctrl, output logic [31:0] acc_addr,
                            output logic [31:0] acc_wd);
        d_req        = 1'b1;
        d_addr       = a;
        d_wdata      = wd;
        d_write_ctrl = wc;
        d_read_ctrl  = rc;
        lat      = 0;
        acc_ctrl = 32'd0;
        acc_addr = 32'd0;
        acc_wd   = 32'd0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                acc_ctrl = {27'd0, mem_write_ctrl, mem_read_ctrl};
                acc_addr = mem_addr;
                acc_wd   = mem_wdata;
            end
            if (d_ack) break;
        end
        rd           = d_rdata;
        d_req        = 1'b0;
        d_write_ctrl = 2'b00;
        d_read_ctrl  = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, actl, aadr, awd, dv;
        logic [11:0] pi, pd;
        logic        seen;
        int          lat, ti, td;

        preload(9'h100, 32'hDEADBEEF);
        preload(9'h080, 32'h01020304);
        preload(9'h040, 32'h00000000);

        @(negedge clk);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_i_ack",  {31'd0, i_ack}, 32'd0);
        chk("rst_d_ack",  {31'd0, d_ack}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_ctrl", {27'd0, mem_write_ctrl, mem_read_ctrl}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Instruction fetch
        i_req  = 1'b1;
        i_addr = 32'h100;
        @(negedge clk);
        chk("if_acc_busy", {31'd0, busy}, 32'd1);
        chk("if_acc_rctrl", {29'd0, mem_read_ctrl}, 32'd1);
        chk("if_acc_wctrl", {30'd0, mem_write_ctrl}, 32'd0);
        chk("if_acc_addr", mem_addr, 32'h100);
        chk("if_acc_ack", {31'd0, i_ack}, 32'd0);
        @(negedge clk);
        chk("if_resp_ack", {31'd0, i_ack}, 32'd1);
        chk("if_resp_rdata", i_rdata, 32'hDEADBEEF);
        chk("if_resp_rctrl", {29'd0, mem_read_ctrl}, 32'd0);
        chk("if_resp_dack", {31'd0, d_ack}, 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        chk("if_idle_ack", {31'd0, i_ack}, 32'd0);
        chk("if_idle_busy", {31'd0, busy}, 32'd0);

        // Store word with a stray read_ctrl that must be forced off
        d_access(2'b11, 3'b001, 32'h40, 32'h12345678, rd, lat, actl, aadr, awd);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_ctrl", actl, 32'h18);
        chk("sw_addr", aadr, 32'h40);
        chk("sw_ram", ram_word(9'h040), 32'h12345678);

        d_access(2'b00, 3'b101, 32'h43, 32'd0, rd, lat, actl, aadr, awd);
        chk("lb43_lat", 32'(lat), 32'd2);
        chk("lb43_rdata", rd, 32'h00000012);

        d_access(2'b01, 3'b000, 32'h41, 32'h000080FF, rd, lat, actl, aadr, awd);
        chk("sh41_ram", ram_word(9'h040), 32'h1280FF78);
        d_access(2'b00, 3'b011, 32'h41, 32'd0, rd, lat, actl, aadr, awd);
        chk("lh41_rdata", rd, 32'hFFFF80FF);
        d_access(2'b00, 3'b010, 32'h41, 32'd0, rd, lat, actl, aadr, awd);
        chk("lhu41_rdata", rd, 32'h000080FF);
        d_access(2'b00, 3'b100, 32'h42, 32'd0, rd, lat, actl, aadr, awd);
        chk("lbu42_rdata", rd, 32'h00000080);
        d_access(2'b00, 3'b101, 32'h42, 32'd0, rd, lat, actl, aadr, awd);
        chk("lb42_rdata", rd, 32'hFFFFFF80);

        // No-op: both controls invalid
        d_access(2'b00, 3'b111, 32'h40, 32'hFFFFFFFF, rd, lat, actl, aadr, awd);
        chk("nop_lat", 32'(lat), 32'd2);
        chk("nop_rdata", rd, 32'd0);
        chk("nop_ctrl", actl, 32'd0);
        chk("nop_addr", aadr, 32'd0);
        chk("nop_wdata", awd, 32'd0);
        chk("nop_i_rdata_held", i_rdata, 32'hDEADBEEF);

        // Both ports held continuously after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        i_req       = 1'b1;
        i_addr      = 32'h100;
        d_req       = 1'b1;
        d_addr      = 32'h40;
        d_read_ctrl = 3'b001;
        dv = 32'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            pi[k] = i_ack;
            pd[k] = d_ack;
            if (d_ack) dv = d_rdata;
        end
        i_req       = 1'b0;
        d_req       = 1'b0;
        d_read_ctrl = 3'b000;
        chk("rr_i_pattern", {20'd0, pi}, 32'h082);
        chk("rr_d_pattern", {20'd0, pd}, 32'h410);
        chk("rr_d_rdata", dv, 32'h1280FF78);
        chk("rr_i_rdata", i_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // D request arriving while an I access is in flight
        i_req  = 1'b1;
        i_addr = 32'h100;
        ti = -1;
        td = -1;
        dv = 32'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                d_req       = 1'b1;
                d_addr      = 32'h100;
                d_read_ctrl = 3'b001;
            end
            if (i_ack) begin
                ti    = k;
                i_req = 1'b0;
            end
            if (d_ack) begin
                td          = k;
                dv          = d_rdata;
                d_req       = 1'b0;
                d_read_ctrl = 3'b000;
            end
        end
        chk("wait_i_ack_cycle", 32'(ti), 32'd2);
        chk("wait_d_after_i", 32'(td - ti), 32'd3);
        chk("wait_d_rdata", dv, 32'hDEADBEEF);

        // Reset during the ACCESS cycle of a store
        d_req        = 1'b1;
        d_addr       = 32'h80;
        d_wdata      = 32'hAAAAAAAA;
        d_write_ctrl = 2'b11;
        @(negedge clk);
        chk("abort_pre_wctrl", {30'd0, mem_write_ctrl}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_wctrl", {30'd0, mem_write_ctrl}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        d_req        = 1'b0;
        d_write_ctrl = 2'b00;
        seen = 1'b0;
        @(negedge clk);
        seen = seen | d_ack;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen = seen | d_ack;
        end
        chk("abort_no_dack", {31'd0, seen}, 32'd0);
        chk("abort_ram", ram_word(9'h080), 32'h01020304);

        // Reset during RESP suppresses the ack
        i_req  = 1'b1;
        i_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        chk("resp_ack_before", {31'd0, i_ack}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("resp_ack_suppressed", {31'd0, i_ack}, 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RESET_PRIO, default 0, port favoured on a tie after reset (0 = I-port, 1 = D-port).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_req  in  1  instruction-fetch request; always a 32-bit word read.
REQ-005 i_addr  in  32  fetch byte address.
REQ-006 i_ack  out  1  one-cycle pulse; i_rdata valid.
REQ-007 i_rdata  out  32  registered fetch data.
REQ-008 d_req  in  1  data-port request.
REQ-009 d_addr  in  32  data byte address.
REQ-010 d_wdata  in  32  store data.
REQ-011 d_write_ctrl  in  2  store size: 11 word, 01 half, 10 byte, 00 none.
REQ-012 d_read_ctrl  in  3  load kind: 001 lw, 010 lhu, 011 lh, 100 lbu, 101 lb, other none.
REQ-013 d_ack  out  1  one-cycle pulse; d_rdata valid on loads.
REQ-014 d_rdata  out  32  registered load data.
REQ-015 mem_addr  out  32  RAM byte address.
REQ-016 mem_wdata  out  32  RAM write data.
REQ-017 mem_write_ctrl  out  2  RAM write control, same encoding as d_write_ctrl.
REQ-018 mem_read_ctrl  out  3  RAM read control, same encoding as d_read_ctrl.
REQ-019 mem_rdata  in  32  combinational RAM read data.
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 FSM states: IDLE, ACCESS, RESP.
REQ-022 IDLE: if any req is high, select a winner, latch its addr, wdata and controls into the request register, and go to ACCESS; otherwise stay in IDLE.
REQ-023 ACCESS lasts exactly one cycle: drive mem_* from the request register; at the closing edge capture mem_rdata into the winner's rdata register and go to RESP.
REQ-024 RESP lasts one cycle: assert the winner's ack only, then go to IDLE.
REQ-025 Latency: req sampled high in IDLE at edge N gives ack high in cycle N+2; maximum throughput is one access per 3 cycles.
REQ-026 Requesters hold req and fields stable until ack, and deassert or change the request in the cycle after ack; fields are sampled only at the IDLE grant edge.
REQ-027 Arbitration with a single req high: grant that port regardless of priority.
REQ-028 Arbitration with both reqs high: grant the port the priority pointer favours.
REQ-029 After every grant, the pointer favours the other port (round-robin).
REQ-030 A req arriving while busy waits; it is not dropped.
REQ-031 I-port grant: latched controls are write_ctrl 00 and read_ctrl 001.
REQ-032 D-port with write_ctrl not 00: it is a store, and latched read_ctrl is forced to 000.
REQ-033 D-port with write_ctrl 00 and read_ctrl in the valid set: it is a load.
REQ-034 D-port with both controls invalid/none: complete as a no-op with d_ack and d_rdata = 0.
REQ-035 d_rdata on a store = 0.
REQ-036 In IDLE and RESP, mem_write_ctrl = 00, mem_read_ctrl = 000, mem_addr = 0, mem_wdata = 0.
REQ-037 The rdata register of the non-winning port holds its previous value.
REQ-038 No address checking in this block; bounds handling belongs to the RAM.

Reset
REQ-039 While rst is high: state IDLE, pointer = RESET_PRIO, i_ack = d_ack = 0, i_rdata = d_rdata = 0, busy = 0, all mem_* = 0, request register cleared.
REQ-040 Reset during ACCESS aborts the access: mem_write_ctrl drops to 00 immediately, so no RAM write occurs at that edge.
REQ-041 Reset during RESP suppresses the ack pulse.
REQ-042 After rst deasserts, the first grant is evaluated in the first IDLE cycle.

Structure
REQ-043 Shared package mem_pkg holds the write_ctrl/read_ctrl encoding constants and arb_state_t (IDLE, ACCESS, RESP).
REQ-044 Sub-module rr_arbiter2 holds the 2-way round-robin pointer and combinational grant; everything else lives in mem_arbiter.

Verification
REQ-045 Reset, then i_req with i_addr 0x100 and RAM word 0xDEADBEEF -> i_ack at cycle +2, i_rdata 0xDEADBEEF, mem_read_ctrl 001 only during ACCESS.
REQ-046 d_req store word 0x12345678 to 0x40, then lb at 0x43 -> RAM holds 78 56 34 12 at 0x40..0x43; d_rdata 0x00000012; 0x41 with lh on stored 0x80FF -> 0xFFFF80FF.
REQ-047 i_req and d_req held continuously with RESET_PRIO=0 -> grant order I, D, I, D; each ack 3 cycles apart; no starvation.
REQ-048 d_req held while an I access is in ACCESS -> D granted at the next IDLE; d_ack exactly 3 cycles after i_ack.
REQ-049 rst pulsed during ACCESS of a store word 0xAAAAAAAA to 0x80 -> RAM at 0x80 unchanged; no d_ack; busy = 0.
REQ-050 d_req with write_ctrl 00 and read_ctrl 111 -> d_ack at +2, d_rdata 0, mem_* idle values throughout.
